// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: ALU opcodes and FSM state type shared by the mips_alu_mc slice.
package mips_alu_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MUL  = 4'b1000;
  localparam logic [3:0] ALU_DIVU = 4'b1001;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: one-bit-per-cycle unsigned shift-add multiplier / restoring divider.
// The divider half is built only when ALU_DIVU_EN is defined.
module alu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  logic [2*WIDTH-1:0] p, p_nxt;
  logic [WIDTH-1:0] m;
  logic [CNT_W-1:0] cnt;
  assign done = cnt == CNT_W'(WIDTH);
  assign {hi, lo} = p;
`ifdef ALU_DIVU_EN
  logic md;
  logic [WIDTH:0] x;
  logic [WIDTH+1:0] y, s;
  // One adder serves both: add multiplicand to HI, or subtract divisor from shifted remainder.
  always_comb begin
    x = md ? p[2*WIDTH-1:WIDTH-1] : {1'b0, p[2*WIDTH-1:WIDTH]};
    y = md ? ~{2'b0, m} : (p[0] ? {2'b0, m} : '0);
    s = {1'b0, x} + y + (WIDTH+2)'(md);
    p_nxt = md ? {(s[WIDTH+1] ? p[2*WIDTH-2:WIDTH-1] : s[WIDTH-1:0]), p[WIDTH-2:0], ~s[WIDTH+1]}
               : {s[WIDTH:0], p[WIDTH-1:1]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) md <= 1'b0;
    else if (start) md <= mode;
`else
  logic [WIDTH:0] s;
  assign s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
  assign p_nxt = {s, p[WIDTH-1:1]};
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p   <= '0;
      m   <= '0;
      cnt <= '0;
    end else if (start) begin
      p   <= {{WIDTH{1'b0}}, mode ? a : b};
      m   <= mode ? b : a;
      cnt <= '0;
    end else if (!done) begin
      p   <= p_nxt;
      cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/mips_alu_mc.sv
// mips_alu_mc: multi-cycle MIPS execute ALU with valid/ready handshakes.
// Define ALU_DIVU_EN to build iterative DIVU (op 1001); otherwise it is an undefined op.
module mips_alu_mc
  import mips_alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit SLT_SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_by_zero
);
`ifdef ALU_DIVU_EN
  localparam bit DIVU_EN = 1'b1;
`else
  localparam bit DIVU_EN = 1'b0;
`endif
  state_t state;
  logic [WIDTH-1:0] sc_res, md_hi, md_lo;
  logic lt, dz, iter, md_done;
  assign in_ready = state == IDLE;
  assign lt = SLT_SIGNED ? $signed(operand1) < $signed(operand2) : operand1 < operand2;
  assign sc_res = alu_op == ALU_ADD ? operand1 + operand2 :
                  alu_op == ALU_SUB ? operand1 - operand2 :
                  alu_op == ALU_AND ? operand1 & operand2 :
                  alu_op == ALU_OR  ? operand1 | operand2 :
                  alu_op == ALU_SLT ? {{(WIDTH-1){1'b0}}, lt} : '0;
  // Divide by zero short-circuits the iterative path and answers in one cycle.
  assign dz   = DIVU_EN && alu_op == ALU_DIVU && operand2 == '0;
  assign iter = alu_op == ALU_MUL || (DIVU_EN && alu_op == ALU_DIVU && operand2 != '0);
  alu_iter_muldiv #(.WIDTH(WIDTH)) u_md (
    .clk   (clk),
    .rst_n (rst_n),
    .start (in_valid && in_ready && iter),
    .mode  (alu_op == ALU_DIVU),
    .a     (operand1),
    .b     (operand2),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        state       <= iter ? BUSY : DONE;
        out_valid   <= !iter;
        div_by_zero <= dz;
        if (!iter) begin
          result    <= dz ? '1 : sc_res;
          result_hi <= dz ? operand1 : '0;
          zero      <= !dz && sc_res == '0;
        end
      end
    end else if (state == BUSY) begin
      if (md_done) begin
        state     <= DONE;
        out_valid <= 1'b1;
        result    <= md_lo;
        result_hi <= md_hi;
        zero      <= md_lo == '0;
      end
    end else if (out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_mips_alu_mc.sv
// tb_mips_alu_mc: directed vector table plus backpressure and mid-BUSY reset sequences.
module tb_mips_alu_mc;
  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b, lo, hi;
    logic        z, dbz;
    int          lat;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] alu_op = 4'h0;
  logic [31:0] operand1 = '0, operand2 = '0;
  logic in_ready, out_valid, zero, div_by_zero;
  logic [31:0] result, result_hi;
  int n_cmp = 0, n_err = 0;
  vec_t vecs[15];

  always #5 clk = ~clk;

  mips_alu_mc #(.WIDTH(32), .SLT_SIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .operand1(operand1), .operand2(operand2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_hi(result_hi), .zero(zero), .div_by_zero(div_by_zero)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [3:0] op, input logic [31:0] a, b,
                              input logic [31:0] lo, hi, input logic z, dbz, input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.lo = lo; v.hi = hi;
    v.z = z; v.dbz = dbz; v.lat = lat;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int lat;
    bit ir_bad;
    lat = 0;
    ir_bad = 0;
    @(negedge clk);
    chk({v.name, " ready_before"}, in_ready, 1);
    in_valid = 1'b1; alu_op = v.op; operand1 = v.a; operand2 = v.b;
    @(posedge clk);
    #1;
    in_valid = 1'b0; operand1 = 32'hDEADBEEF; operand2 = 32'h12345678; alu_op = 4'b0010;
    for (int k = 1; k <= 100 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat = k;
      else if (in_ready) ir_bad = 1;
    end
    chk({v.name, " latency"}, lat, v.lat);
    chk({v.name, " in_ready_low_while_busy"}, ir_bad, 0);
    chk({v.name, " result"}, result, v.lo);
    chk({v.name, " result_hi"}, result_hi, v.hi);
    chk({v.name, " zero"}, zero, v.z);
    chk({v.name, " div_by_zero"}, div_by_zero, v.dbz);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({v.name, " out_valid_drop"}, out_valid, 0);
    chk({v.name, " in_ready_back"}, in_ready, 1);
    chk({v.name, " result_kept"}, result, v.lo);
  endtask

  initial begin
    int lat;
    vecs[0]  = mk("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1, 0, 1);
    vecs[1]  = mk("sub_neg", 4'b0110, 32'd5, 32'd7, 32'hFFFFFFFE, 32'h0, 0, 0, 1);
    vecs[2]  = mk("sub_wrap", 4'b0110, 32'd0, 32'd1, 32'hFFFFFFFF, 32'h0, 0, 0, 1);
    vecs[3]  = mk("slt_m1_1", 4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1, 32'h0, 0, 0, 1);
    vecs[4]  = mk("slt_1_m1", 4'b0111, 32'd1, 32'hFFFFFFFF, 32'd0, 32'h0, 1, 0, 1);
    vecs[5]  = mk("and", 4'b0000, 32'hF0F0, 32'h0FF0, 32'h00F0, 32'h0, 0, 0, 1);
    vecs[6]  = mk("or", 4'b0001, 32'hF0F0, 32'h0FF0, 32'hFFF0, 32'h0, 0, 0, 1);
    vecs[7]  = mk("mul_max", 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 0, 0, 33);
    vecs[8]  = mk("mul_small", 4'b1000, 32'd12345, 32'd1000, 32'd12345000, 32'h0, 0, 0, 33);
    vecs[9]  = mk("mul_zero", 4'b1000, 32'd0, 32'd5, 32'h0, 32'h0, 1, 0, 33);
`ifdef ALU_DIVU_EN
    vecs[10] = mk("divu_100_7", 4'b1001, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 33);
    vecs[11] = mk("divu_by0", 4'b1001, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 0, 1, 1);
    vecs[13] = mk("divu_max_3", 4'b1001, 32'hFFFFFFFF, 32'd3, 32'h55555555, 32'd0, 0, 0, 33);
`else
    vecs[10] = mk("divu_100_7", 4'b1001, 32'd100, 32'd7, 32'h0, 32'h0, 1, 0, 1);
    vecs[11] = mk("divu_by0", 4'b1001, 32'd9, 32'd0, 32'h0, 32'h0, 1, 0, 1);
    vecs[13] = mk("divu_max_3", 4'b1001, 32'hFFFFFFFF, 32'd3, 32'h0, 32'h0, 1, 0, 1);
`endif
    vecs[12] = mk("add_clears_dbz", 4'b0010, 32'd2, 32'd3, 32'd5, 32'h0, 0, 0, 1);
    vecs[14] = mk("undef_op", 4'b1111, 32'd3, 32'd4, 32'h0, 32'h0, 1, 0, 1);

    #2;
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst result", {result_hi, result}, 64'h0);
    chk("rst flags", {zero, div_by_zero}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: result of 7*6 must hold while out_ready stays low.
    @(negedge clk);
    in_valid = 1'b1; alu_op = 4'b1000; operand1 = 32'd7; operand2 = 32'd6;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat = k;
    end
    chk("bp latency", lat, 33);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1; alu_op = 4'b0010; operand1 = 32'd1; operand2 = 32'd1;
      @(posedge clk);
      #1;
      chk("bp result", {result_hi, result}, 64'd42);
      chk("bp out_valid", out_valid, 1);
      chk("bp in_ready", in_ready, 0);
      chk("bp zero", zero, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp release out_valid", out_valid, 0);
    chk("bp release in_ready", in_ready, 1);
    chk("bp release result", result, 32'd42);
    @(posedge clk);
    #1;
    chk("bp idle stays", {in_ready, out_valid}, 2'b10);

    // Reset during BUSY of a MUL aborts it.
    @(negedge clk);
    in_valid = 1'b1; alu_op = 4'b1000; operand1 = 32'hFFFFFFFF; operand2 = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("busy in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort in_ready", in_ready, 1);
    chk("abort out_valid", out_valid, 0);
    chk("abort result", {result_hi, result}, 64'h0);
    chk("abort flags", {zero, div_by_zero}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(mk("add_after_abort", 4'b0010, 32'd2, 32'd3, 32'd5, 32'h0, 0, 0, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
